// File: rtl/csr_counter_arbiter_if.sv
// Bus bundle for csr_counter_arbiter.
// Carries the requester side (req_*/rsp_*) and the CSR counter unit read port
// (csr_*). The arbiter takes the slave modport. The master modport is the
// environment around it: the requesters together with the counter unit.
interface csr_counter_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*12-1:0] req_csr;
  logic [NUM_REQ-1:0]    req_wide;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [63:0]           rsp_data;
  logic                  rsp_err;
  logic [11:0]           csr_addr;
  logic                  csr_rd;
  logic [31:0]           csr_rdata;
  logic                  csr_hit;

  modport master (
    output req_valid, req_csr, req_wide, csr_rdata, csr_hit,
    input  req_ready, rsp_valid, rsp_data, rsp_err, csr_addr, csr_rd
  );

  modport slave (
    input  req_valid, req_csr, req_wide, csr_rdata, csr_hit,
    output req_ready, rsp_valid, rsp_data, rsp_err, csr_addr, csr_rd
  );
endinterface

// File: rtl/csr_counter_arbiter.sv
// csr_counter_arbiter
// Shares the single 32-bit read port of the CSR counter unit among NUM_REQ
// requesters with round-robin grant. Narrow reads pass one address through.
// Wide reads are sequenced so that the returned {hi, lo} pair is consistent.
//
// Build option CSR_ARB_TORN_CHECK_EN:
//   defined   - wide read is hi, lo, hi. The second hi is compared with the
//               first one. On a mismatch the lo/hi pair is re-read, up to
//               MAX_RETRY times, and then the last values are accepted.
//   undefined - wide read is lo then hi with no compare. MAX_RETRY is unused.
module csr_counter_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_RETRY = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  csr_counter_arbiter_if.slave  bus
);

  localparam int          PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [11:0] HI_OFS = 12'h080;

  if (NUM_REQ < 2 || MAX_RETRY < 0) begin : g_cfg_check
    $error("csr_counter_arbiter: NUM_REQ must be >= 2 and MAX_RETRY >= 0");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_HI1 = 3'd1,
    RD_LO  = 3'd2,
    RD_HI2 = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] gnt_idx, gnt_q;
  logic             gnt_any;
  logic [11:0]      gnt_csr, csr_q;
  logic             gnt_wide, wide_q;
  logic             bad_q;   // wide request already addressed the hi half
  logic             err_q;
  logic [31:0]      lo_q, hi_q;

`ifdef CSR_ARB_TORN_CHECK_EN
  localparam int                 RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  logic [RETRY_W-1:0] retry_cnt;
  logic               hi_done;

  // The snapshot is accepted once hi is stable, the retry budget is spent, or
  // an error already makes the data meaningless.
  assign hi_done = (bus.csr_rdata == hi_q) || (retry_cnt == RETRY_MAX) || err_q;
`endif

  // Round-robin pick: first pending requester at or after rr_ptr, wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    gnt_csr  = '0;
    gnt_wide = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!gnt_any && (i == (int'(rr_ptr) + k) % NUM_REQ) && bus.req_valid[i]) begin
          gnt_any  = 1'b1;
          gnt_idx  = PTR_W'(i);
          gnt_csr  = bus.req_csr[12*i +: 12];
          gnt_wide = bus.req_wide[i];
        end
      end
    end
  end

  // One-cycle accept strobe, only while idle and out of reset.
  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && gnt_any && !reset) begin
      bus.req_ready[gnt_idx] = 1'b1;
    end
  end

  // Next-state logic and read strobe to the counter unit.
  always_comb begin
    state_nxt    = state;
    bus.csr_rd   = 1'b0;
    bus.csr_addr = '0;
    case (state)
      IDLE: begin
        if (gnt_any) begin
`ifdef CSR_ARB_TORN_CHECK_EN
          state_nxt = gnt_wide ? RD_HI1 : RD_LO;
`else
          state_nxt = RD_LO;
`endif
        end
      end
      RD_LO: begin
        if (bad_q) begin
          state_nxt = RESP;
        end else begin
          bus.csr_rd   = 1'b1;
          bus.csr_addr = csr_q;
          if (!wide_q) begin
            state_nxt = RESP;
          end else begin
`ifdef CSR_ARB_TORN_CHECK_EN
            state_nxt = RD_HI2;
`else
            state_nxt = RD_HI1;
`endif
          end
        end
      end
      RD_HI1: begin
        if (bad_q) begin
          state_nxt = RESP;
        end else begin
          bus.csr_rd   = 1'b1;
          bus.csr_addr = csr_q | HI_OFS;
`ifdef CSR_ARB_TORN_CHECK_EN
          state_nxt = RD_LO;
`else
          state_nxt = RESP;
`endif
        end
      end
`ifdef CSR_ARB_TORN_CHECK_EN
      RD_HI2: begin
        bus.csr_rd   = 1'b1;
        bus.csr_addr = csr_q | HI_OFS;
        state_nxt    = hi_done ? RESP : RD_LO;
      end
`endif
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Response outputs are driven only in RESP and are zero everywhere else.
  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_data  = '0;
    bus.rsp_err   = 1'b0;
    if (state == RESP) begin
      bus.rsp_valid[gnt_q] = 1'b1;
      bus.rsp_data         = wide_q ? {hi_q, lo_q} : {32'h0, lo_q};
      bus.rsp_err          = err_q;
    end
  end

  // State register, grant bookkeeping and data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      gnt_q  <= '0;
      csr_q  <= '0;
      wide_q <= 1'b0;
      bad_q  <= 1'b0;
      err_q  <= 1'b0;
      lo_q   <= '0;
      hi_q   <= '0;
`ifdef CSR_ARB_TORN_CHECK_EN
      retry_cnt <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register here samples values from before the clock edge.
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            gnt_q  <= gnt_idx;
            csr_q  <= gnt_csr;
            wide_q <= gnt_wide;
            bad_q  <= gnt_wide & gnt_csr[7];
            err_q  <= gnt_wide & gnt_csr[7];
            lo_q   <= '0;
            hi_q   <= '0;
            rr_ptr <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          end
        end
        RD_LO: begin
          if (!bad_q) begin
            lo_q  <= bus.csr_rdata;
            err_q <= err_q | ~bus.csr_hit;
          end
        end
        RD_HI1: begin
          if (!bad_q) begin
            hi_q  <= bus.csr_rdata;
            err_q <= err_q | ~bus.csr_hit;
          end
        end
`ifdef CSR_ARB_TORN_CHECK_EN
        RD_HI2: begin
          hi_q  <= bus.csr_rdata;
          err_q <= err_q | ~bus.csr_hit;
          if (!hi_done) begin
            retry_cnt <= retry_cnt + 1'b1;
          end
        end
`endif
        RESP: begin
          err_q <= 1'b0;
          bad_q <= 1'b0;
`ifdef CSR_ARB_TORN_CHECK_EN
          retry_cnt <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_counter_arbiter.sv
// Directed bench for csr_counter_arbiter.
// The bench models the CSR counter unit. Its implemented counters are
// 0xC00-0xC02 (lo) and 0xC80-0xC82 (hi). It also provides a "torn" mode and a
// "churn" mode, in which returned values depend on how many reads were made.
`timescale 1ns/1ps
module tb_csr_counter_arbiter;

  localparam int NUM_REQ   = 2;
  localparam int MAX_RETRY = 3;

  logic clk = 1'b0;
  logic reset;

  csr_counter_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  csr_counter_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Counter unit model: 0 = static table, 1 = torn lo wrap, 2 = hi changes on every read.
  int          mode     = 0;
  int          hi_reads = 0;
  int          lo_reads = 0;
  int          hi_base  = 0;
  int          lo_base  = 0;
  logic [31:0] lo_tab [3];
  logic [31:0] hi_tab [3];
  int          hr, lr;

  always @(posedge clk) begin
    if (bus.csr_rd) begin
      if (bus.csr_addr[7]) hi_reads <= hi_reads + 1;
      else                 lo_reads <= lo_reads + 1;
    end
  end

  always_comb begin
    hr            = hi_reads - hi_base;
    lr            = lo_reads - lo_base;
    bus.csr_hit   = (bus.csr_addr[11:8] == 4'hC) && (bus.csr_addr[6:2] == 5'd0) &&
                    (bus.csr_addr[1:0] != 2'b11);
    bus.csr_rdata = '0;
    if (bus.csr_hit) begin
      case (mode)
        1:       bus.csr_rdata = bus.csr_addr[7] ? ((hr == 0) ? 32'd1 : 32'd2)
                                                 : ((lr == 0) ? 32'hFFFF_FFFF : 32'd5);
        2:       bus.csr_rdata = bus.csr_addr[7] ? 32'(hr) : 32'hA000_0000 + 32'(lr);
        default: bus.csr_rdata = bus.csr_addr[7] ? hi_tab[bus.csr_addr[1:0]]
                                                 : lo_tab[bus.csr_addr[1:0]];
      endcase
    end
  end

  // Issue one request and wait for its response. Must be called away from the
  // rising edge. lat counts cycles from accept to rsp_valid and stays -1 when
  // no response arrives.
  task automatic do_req(input  string                tag,
                        input  int                   idx,
                        input  logic [11:0]          csr,
                        input  logic                 wide,
                        output int                   lat,
                        output logic [NUM_REQ-1:0]   rv,
                        output logic [63:0]          data,
                        output logic                 err,
                        output logic                 saw_rd,
                        output logic [11:0]          first_addr);
    int wait_cyc;
    lat        = -1;
    rv         = '0;
    data       = '0;
    err        = 1'b0;
    saw_rd     = 1'b0;
    first_addr = '0;
    bus.req_csr[12*idx +: 12] = csr;
    bus.req_wide[idx]         = wide;
    bus.req_valid[idx]        = 1'b1;
    #1;
    wait_cyc = 0;
    while (!bus.req_ready[idx] && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    check({tag, "_grant"}, 64'(bus.req_ready), 64'(1 << idx));
    if (!bus.req_ready[idx]) begin
      bus.req_valid[idx] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.req_valid[idx] = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (bus.csr_rd && !saw_rd) begin
        saw_rd     = 1'b1;
        first_addr = bus.csr_addr;
      end
      if (bus.rsp_valid != '0) begin
        lat  = c;
        rv   = bus.rsp_valid;
        data = bus.rsp_data;
        err  = bus.rsp_err;
        break;
      end
    end
  endtask

  int                 lat;
  logic [NUM_REQ-1:0] rv;
  logic [63:0]        data;
  logic               err, saw_rd;
  logic [11:0]        faddr;
  int                 exp_g [4];
  logic               seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    lo_tab = '{32'h0000_1234, 32'h1234_5678, 32'hDEAD_BEEF};
    hi_tab = '{32'h0000_0000, 32'h0000_0009, 32'h0000_0077};
    reset         = 1'b1;
    bus.req_valid = '1;
    bus.req_wide  = '0;
    bus.req_csr   = {12'hC00, 12'hC00};

    // Reset state, with both requesters already pending.
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'h0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    check("rst_rsp_data",  bus.rsp_data,       64'h0);
    check("rst_rsp_err",   64'(bus.rsp_err),   64'h0);
    check("rst_csr_rd",    64'(bus.csr_rd),    64'h0);
    check("rst_csr_addr",  64'(bus.csr_addr),  64'h0);

    // Round robin from reset: both held valid, grants must alternate 0,1,0,1.
    @(posedge clk);
    #1 reset = 1'b0;
    exp_g = '{0, 1, 0, 1};
    for (int n = 0; n < 4; n++) begin
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (bus.req_ready != '0) break;
      end
      check($sformatf("rr_grant%0d", n), 64'(bus.req_ready), 64'(1 << exp_g[n]));
    end
    @(posedge clk);
    #1 bus.req_valid = '0;
    repeat (4) @(negedge clk);

    // Narrow reads from both requesters.
    do_req("nar0", 0, 12'hC00, 1'b0, lat, rv, data, err, saw_rd, faddr);
    check("nar0_lat",  64'(lat),   64'd2);
    check("nar0_rv",   64'(rv),    64'h1);
    check("nar0_data", data,       64'h0000_0000_0000_1234);
    check("nar0_err",  64'(err),   64'h0);
    check("nar0_addr", 64'(faddr), 64'hC00);

    do_req("nar1", 1, 12'hC02, 1'b0, lat, rv, data, err, saw_rd, faddr);
    check("nar1_lat",  64'(lat),   64'd2);
    check("nar1_rv",   64'(rv),    64'h2);
    check("nar1_data", data,       64'h0000_0000_DEAD_BEEF);

    // Wide read with stable counter.
    do_req("wide", 0, 12'hC01, 1'b1, lat, rv, data, err, saw_rd, faddr);
    check("wide_data", data,     64'h0000_0009_1234_5678);
    check("wide_err",  64'(err), 64'h0);
`ifdef CSR_ARB_TORN_CHECK_EN
    check("wide_lat",  64'(lat),   64'd4);
    check("wide_addr", 64'(faddr), 64'hC81);

    // Torn value: hi=1 first, lo=FFFF_FFFF, then hi=2 -> one retry, lo=5.
    mode    = 1;
    hi_base = hi_reads;
    lo_base = lo_reads;
    do_req("torn", 1, 12'hC00, 1'b1, lat, rv, data, err, saw_rd, faddr);
    check("torn_lat",  64'(lat), 64'd6);
    check("torn_rv",   64'(rv),  64'h2);
    check("torn_data", data,     64'h0000_0002_0000_0005);

    // Retry cap: hi changes on every read -> 1 HI1 read + 4 HI2 reads.
    mode    = 2;
    hi_base = hi_reads;
    lo_base = lo_reads;
    do_req("cap", 0, 12'hC00, 1'b1, lat, rv, data, err, saw_rd, faddr);
    check("cap_lat",     64'(lat),                64'd10);
    check("cap_hireads", 64'(hi_reads - hi_base), 64'd5);
    check("cap_data",    data,                    64'h0000_0004_A000_0003);
    mode = 0;
`else
    check("wide_lat",  64'(lat),   64'd3);
    check("wide_addr", 64'(faddr), 64'hC01);
`endif

    // Errors: unimplemented address, and a wide read of an already-hi address.
    do_req("enar", 1, 12'h123, 1'b0, lat, rv, data, err, saw_rd, faddr);
    check("enar_lat", 64'(lat), 64'd2);
    check("enar_err", 64'(err), 64'h1);

    do_req("ewide", 0, 12'hC80, 1'b1, lat, rv, data, err, saw_rd, faddr);
    check("ewide_err", 64'(err),    64'h1);
    check("ewide_rv",  64'(rv),     64'h1);
    check("ewide_rd",  64'(saw_rd), 64'h0);

    // Reset in RD_LO aborts: no response, then normal service resumes.
    bus.req_csr[11:0] = 12'hC00;
    bus.req_wide[0]   = 1'b0;
    bus.req_valid[0]  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.req_ready[0]) break;
    end
    @(posedge clk);
    #1;
    bus.req_valid[0] = 1'b0;
    check("rlo_csr_rd", 64'(bus.csr_rd), 64'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rlo_rd",   64'(bus.csr_rd),    64'h0);
    check("rlo_addr", 64'(bus.csr_addr),  64'h0);
    check("rlo_rv",   64'(bus.rsp_valid), 64'h0);
    check("rlo_data", bus.rsp_data,       64'h0);
    check("rlo_err",  64'(bus.rsp_err),   64'h0);
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) seen = 1'b1;
    end
    check("rlo_no_rsp", 64'(seen), 64'h0);

    do_req("post", 1, 12'hC02, 1'b0, lat, rv, data, err, saw_rd, faddr);
    check("post_lat",  64'(lat), 64'd2);
    check("post_rv",   64'(rv),  64'h2);
    check("post_data", data,     64'h0000_0000_DEAD_BEEF);
    check("post_err",  64'(err), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
